// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational read ports, one write port, $0 reads as zero
module reg_file (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  a1,
   input  logic [4:0]  a2,
   input  logic [4:0]  a3,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] regs [32];
   // a3 == 0 doubles as "no write"; reads are unbypassed so wd may depend on rd1/rd2
   always_ff @(posedge clk)
      if (!reset) for (int i = 0; i < 32; i++) regs[i] <= '0;
      else if (a3 != 5'd0) regs[a3] <= wd;
   assign rd1 = (a1 == 5'd0) ? '0 : regs[a1];
   assign rd2 = (a2 == 5'd0) ? '0 : regs[a2];
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard-driven checks of reset, writes, $0 protection, no-bypass and sweep
module tb_reg_file;
   logic        clk, reset;
   logic [4:0]  a1, a2, a3;
   logic [31:0] wd, rd1, rd2, e;
   logic [31:0] m [32];
   logic [31:0] sb [$];
   int total = 0, bad = 0;

   reg_file dut (.clk(clk), .reset(reset), .a1(a1), .a2(a2), .a3(a3), .wd(wd), .rd1(rd1), .rd2(rd2));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      a3 = a;
      wd = d;
      @(posedge clk);
      #1;
      if (reset && a != 5'd0) m[a] = d;
      a3 = 5'd0;
   endtask

   task automatic test_reset;
      reset = 0;
      a1 = 0; a2 = 0; a3 = 0; wd = 0;
      @(negedge clk);
      a3 = 5'd5;
      wd = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      reset = 1;
      a3 = 0;
      for (int i = 0; i < 32; i++) m[i] = '0;
      a1 = 5'd5; a2 = 5'd31;
      sb.push_back(32'h0); sb.push_back(32'h0);
      #1;
      e = sb.pop_front(); total++;
      if (rd1 !== e) begin bad++; $display("FAIL reset_discard rd1: got %h want %h", rd1, e); end
      e = sb.pop_front(); total++;
      if (rd2 !== e) begin bad++; $display("FAIL reset_discard rd2: got %h want %h", rd2, e); end
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i); a2 = 5'(31 - i);
         sb.push_back(32'h0); sb.push_back(32'h0);
         #1;
         e = sb.pop_front(); total++;
         if (rd1 !== e) begin bad++; $display("FAIL reset_state rd1[%0d]: got %h want %h", i, rd1, e); end
         e = sb.pop_front(); total++;
         if (rd2 !== e) begin bad++; $display("FAIL reset_state rd2[%0d]: got %h want %h", 31 - i, rd2, e); end
      end
   endtask

   task automatic test_write_read;
      wr(5'd8, 32'h12345678);
      wr(5'd31, 32'hFFFFFFFF);
      a1 = 5'd8; a2 = 5'd31;
      sb.push_back(32'h12345678); sb.push_back(32'hFFFFFFFF);
      #1;
      e = sb.pop_front(); total++;
      if (rd1 !== e) begin bad++; $display("FAIL write_read rd1: got %h want %h", rd1, e); end
      e = sb.pop_front(); total++;
      if (rd2 !== e) begin bad++; $display("FAIL write_read rd2: got %h want %h", rd2, e); end
      a2 = 5'd8;
      sb.push_back(32'h12345678); sb.push_back(32'h12345678);
      #1;
      e = sb.pop_front(); total++;
      if (rd1 !== e) begin bad++; $display("FAIL same_addr rd1: got %h want %h", rd1, e); end
      e = sb.pop_front(); total++;
      if (rd2 !== e) begin bad++; $display("FAIL same_addr rd2: got %h want %h", rd2, e); end
   endtask

   task automatic test_zero_reg;
      wr(5'd0, 32'hAAAAAAAA);
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i); a2 = 5'(i);
         sb.push_back(i == 0 ? 32'h0 : m[i]); sb.push_back(i == 0 ? 32'h0 : m[i]);
         #1;
         e = sb.pop_front(); total++;
         if (rd1 !== e) begin bad++; $display("FAIL zero_reg rd1[%0d]: got %h want %h", i, rd1, e); end
         e = sb.pop_front(); total++;
         if (rd2 !== e) begin bad++; $display("FAIL zero_reg rd2[%0d]: got %h want %h", i, rd2, e); end
      end
   endtask

   task automatic test_no_bypass;
      wr(5'd4, 32'h11);
      @(negedge clk);
      a1 = 5'd4; a3 = 5'd4; wd = 32'h22;
      sb.push_back(32'h11);
      #1;
      e = sb.pop_front(); total++;
      if (rd1 !== e) begin bad++; $display("FAIL no_bypass_before: got %h want %h", rd1, e); end
      sb.push_back(32'h22);
      @(posedge clk);
      #1;
      m[4] = 32'h22;
      a3 = 0;
      e = sb.pop_front(); total++;
      if (rd1 !== e) begin bad++; $display("FAIL no_bypass_after: got %h want %h", rd1, e); end
   endtask

   task automatic test_sweep;
      for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i); a2 = 5'(31 - i);
         sb.push_back(32'(i) * 32'h01010101); sb.push_back(32'(31 - i) * 32'h01010101);
         #1;
         e = sb.pop_front(); total++;
         if (rd1 !== e) begin bad++; $display("FAIL sweep rd1[%0d]: got %h want %h", i, rd1, e); end
         e = sb.pop_front(); total++;
         if (rd2 !== e) begin bad++; $display("FAIL sweep rd2[%0d]: got %h want %h", 31 - i, rd2, e); end
      end
   endtask

   task automatic test_midrun_reset;
      @(negedge clk);
      reset = 0;
      a3 = 5'd7;
      wd = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      reset = 1;
      a3 = 0;
      for (int i = 0; i < 32; i++) m[i] = '0;
      for (int i = 0; i < 32; i++) begin
         a1 = 5'(i); a2 = 5'(i);
         sb.push_back(32'h0); sb.push_back(32'h0);
         #1;
         e = sb.pop_front(); total++;
         if (rd1 !== e) begin bad++; $display("FAIL midrun_reset rd1[%0d]: got %h want %h", i, rd1, e); end
         e = sb.pop_front(); total++;
         if (rd2 !== e) begin bad++; $display("FAIL midrun_reset rd2[%0d]: got %h want %h", i, rd2, e); end
      end
      wr(5'd9, 32'h0BADF00D);
      a1 = 5'd9;
      sb.push_back(32'h0BADF00D);
      #1;
      e = sb.pop_front(); total++;
      if (rd1 !== e) begin bad++; $display("FAIL post_reset_write: got %h want %h", rd1, e); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_zero_reg;
      test_no_bypass;
      test_sweep;
      test_midrun_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
